control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 HALT_OP, 4'hF, opcode that stops sequencing.
REQ-002 Clock  input  1  single clock, rising edge, shared with ALU_System.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 IROut  input  16  instruction register contents.
REQ-005 ALUOutFlag  input  4  ALU flags, [3]=Z.
REQ-006 Step  input  1  single-step advance request.
REQ-007 RF_OutASel  output  3  RF port A select.
REQ-008 RF_OutBSel  output  3  RF port B select.
REQ-009 RF_FunSel  output  2  RF function.
REQ-010 RF_RSel  output  4  RF R1..R4 enables.
REQ-011 RF_TSel  output  4  RF T1..T4 enables.
REQ-012 ALU_FunSel  output  4  ALU function.
REQ-013 ARF_OutCSel  output  2  ARF port C select, fixed 0.
REQ-014 ARF_OutDSel  output  2  ARF address port select.
REQ-015 ARF_FunSel  output  2  ARF function.
REQ-016 ARF_RegSel  output  4  ARF enables, [3]=PC [2]=AR [1]=SP [0]=PCPast.
REQ-017 IR_LH  output  1  IR byte select, 0=low.
REQ-018 IR_Enable  output  1  IR write enable.
REQ-019 IR_Funsel  output  2  IR function.
REQ-020 Mem_WR  output  1  1=write.
REQ-021 Mem_CS  output  1  chip select, active-low.
REQ-022 MuxASel  output  2  RF input mux.
REQ-023 MuxBSel  output  2  ARF input mux.
REQ-024 MuxCSel  output  1  ALU A-input mux.
REQ-025 State  output  3  current state code.

Function
REQ-026 Outputs SHALL be a combinational decode of state, IROut and the Z latch; every register write takes effect at the rising edge ending the state.
REQ-027 Idle value of every field not listed for a state SHALL be: all enables 0, Mem_CS=1, Mem_WR=0, every other select/funsel 0.
REQ-028 States SHALL be INIT=0, F0=1, F1=2, E0=3, E1=4, HLT=5; INIT->F0->F1->E0; E0->E1 for LD/ST, ->HLT for HALT_OP, else ->F0; E1->F0; HLT holds until Reset.
REQ-029 INIT SHALL clear all registers: RF_RSel=RF_TSel=ARF_RegSel=4'hF, RF_FunSel=ARF_FunSel=00.
REQ-030 F0 SHALL drive ARF_OutDSel=3, Mem_CS=0, IR_Enable=1, IR_Funsel=01, IR_LH=0, ARF_RegSel=1000, ARF_FunSel=11 (PC+1); F1 SHALL be identical except IR_LH=1.
REQ-031 Fields SHALL be op=IROut[15:12], x=[11:10], y=[9:8], imm=[7:0]; register Rn (n=0..3) SHALL use OutSel 4+n and RSel 4'b1000>>n.
REQ-032 op 0 LD: E0 AR<=imm (MuxBSel=2, ARF_FunSel=01, ARF_RegSel=0100); E1 Rx<=M[AR] (ARF_OutDSel=0, Mem_CS=0, MuxASel=1, RF_FunSel=01).
REQ-033 op 1 ST: E0 as LD; E1 M[AR]<=Rx (ARF_OutDSel=0, Mem_CS=0, Mem_WR=1, RF_OutASel=Rx, MuxCSel=0, ALU_FunSel=0).
REQ-034 op 2 LDI: E0 Rx<=imm (MuxASel=2, RF_FunSel=01).
REQ-035 op 3 ALU: E0 Rx<=Rx op Ry (ALU_FunSel=imm[7:4], MuxCSel=0, MuxASel=0, RF_FunSel=01); x==y is legal; Z latch<=ALUOutFlag[3] at the end of E0, and only here.
REQ-036 op 4 BRA: E0 PC<=imm (MuxBSel=2, ARF_FunSel=01, ARF_RegSel=1000); op 5 BEQ: same as BRA when Z latch=1, else idle.
REQ-037 All other opcodes except HALT_OP SHALL be NOPs (E0 idle); HLT SHALL drive idle values.

Reset
REQ-038 While Reset=1: state=INIT, Z latch=0, outputs=INIT decode immediately; mid-instruction assertion abandons the instruction (Mem_WR drops the same cycle).
REQ-039 After release: exactly one INIT cycle, then F0 fetching from PC=0.

Configuration
REQ-040 SINGLE_STEP_EN defined: F0 drives idle values and holds until Step=1 at a rising edge, then fetches; undefined: Step ignored and F0 always fetches.

Verification
REQ-041 Reset, M[0]=8'h42, M[1]=8'h20 -> State 0,1,2,3,1; R1=8'h42.
REQ-042 LD word 8'h04/8'h10 at M[2..3], M[8'h10]=8'h5A -> State 1,2,3,4,1; AR=8'h10, R2=8'h5A.
REQ-043 R1=8'h42, ALU word 16'h3050 then BEQ 16'h5008 -> R1=0, Z latch=1, PC=8'h08.
REQ-044 Word 16'hF000 -> State=5 for 10+ cycles, Mem_CS=1, all enables 0.
REQ-045 Reset asserted during E1 of ST -> Mem_WR=0 the same cycle, State=0, target memory byte unchanged; with SINGLE_STEP_EN, Step=0 for 5 cycles -> State=1 and PC unchanged.

Source files
------------

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control unit <-> datapath signal bundle
interface control_unit_if;
  // datapath -> control unit
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic        Step;
  // control unit -> datapath
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel;
  logic [3:0]  RF_TSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  ARF_OutCSel;
  logic [1:0]  ARF_OutDSel;
  logic [1:0]  ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic        IR_LH;
  logic        IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR;
  logic        Mem_CS;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic        MuxCSel;
  logic [2:0]  State;

  modport master (
    input  IROut, ALUOutFlag, Step,
    output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
           ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
           IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel, State
  );

  modport slave (
    output IROut, ALUOutFlag, Step,
    input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
           ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
           IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel, State
  );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/execute sequencer for the ALU_System datapath (optional SINGLE_STEP_EN)
module control_unit (
  input  logic          Clock,
  input  logic          Reset,
  control_unit_if.master bus
);

  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_ALU  = 4'h3;
  localparam logic [3:0] OP_BRA  = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] HALT_OP = 4'hF;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    F0   = 3'd1,
    F1   = 3'd2,
    E0   = 3'd3,
    E1   = 3'd4,
    HLT  = 3'd5
  } state_t;

  state_t state;
  state_t state_next;
  logic   z_latch;
  logic   step_go;

  logic [3:0] op;
  logic [1:0] fx;
  logic [1:0] fy;
  logic [7:0] imm;
  logic [2:0] rx_sel;
  logic [2:0] ry_sel;
  logic [3:0] rx_en;

  logic [2:0] rf_outa_sel;
  logic [2:0] rf_outb_sel;
  logic [1:0] rf_fun_sel;
  logic [3:0] rf_r_sel;
  logic [3:0] rf_t_sel;
  logic [3:0] alu_fun_sel;
  logic [1:0] arf_outd_sel;
  logic [1:0] arf_fun_sel;
  logic [3:0] arf_reg_sel;
  logic       ir_lh;
  logic       ir_enable;
  logic [1:0] ir_funsel;
  logic       mem_wr;
  logic       mem_cs;
  logic [1:0] mux_a_sel;
  logic [1:0] mux_b_sel;
  logic       mux_c_sel;

  assign op     = bus.IROut[15:12];
  assign fx     = bus.IROut[11:10];
  assign fy     = bus.IROut[9:8];
  assign imm    = bus.IROut[7:0];
  assign rx_sel = {1'b1, fx};
  assign ry_sel = {1'b1, fy};
  assign rx_en  = 4'b1000 >> fx;

`ifdef SINGLE_STEP_EN
  assign step_go = bus.Step;
`else
  assign step_go = 1'b1;
`endif

  // state register; reset abandons whatever instruction is in flight
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // zero flag is captured only at the end of an ALU execute cycle
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      z_latch <= 1'b0;
    end else if (state == E0 && op == OP_ALU) begin
      z_latch <= bus.ALUOutFlag[3];
    end
  end

  // next-state sequencing
  always_comb begin
    state_next = state;
    case (state)
      INIT: state_next = F0;
      F0:   state_next = step_go ? F1 : F0;
      F1:   state_next = E0;
      E0: begin
        if (op == OP_LD || op == OP_ST) begin
          state_next = E1;
        end else if (op == HALT_OP) begin
          state_next = HLT;
        end else begin
          state_next = F0;
        end
      end
      E1:      state_next = F0;
      HLT:     state_next = HLT;
      default: state_next = INIT;
    endcase
  end

  // control word decode from state, instruction fields and Z latch
  always_comb begin
    rf_outa_sel  = 3'd0;
    rf_outb_sel  = 3'd0;
    rf_fun_sel   = 2'd0;
    rf_r_sel     = 4'h0;
    rf_t_sel     = 4'h0;
    alu_fun_sel  = 4'h0;
    arf_outd_sel = 2'd0;
    arf_fun_sel  = 2'd0;
    arf_reg_sel  = 4'h0;
    ir_lh        = 1'b0;
    ir_enable    = 1'b0;
    ir_funsel    = 2'd0;
    mem_wr       = 1'b0;
    mem_cs       = 1'b1;
    mux_a_sel    = 2'd0;
    mux_b_sel    = 2'd0;
    mux_c_sel    = 1'b0;
    case (state)
      INIT: begin
        // clear every RF/ARF register so fetching starts at PC=0
        rf_r_sel    = 4'hF;
        rf_t_sel    = 4'hF;
        arf_reg_sel = 4'hF;
        rf_fun_sel  = 2'b00;
        arf_fun_sel = 2'b00;
      end
      F0, F1: begin
        // byte fetch from M[PC] into IR half, PC incremented in the same edge
        if (state == F1 || step_go) begin
          arf_outd_sel = 2'd3;
          mem_cs       = 1'b0;
          ir_enable    = 1'b1;
          ir_funsel    = 2'b01;
          ir_lh        = (state == F1);
          arf_reg_sel  = 4'b1000;
          arf_fun_sel  = 2'b11;
        end
      end
      E0: begin
        case (op)
          OP_LD, OP_ST: begin
            mux_b_sel   = 2'd2;
            arf_fun_sel = 2'b01;
            arf_reg_sel = 4'b0100;
          end
          OP_LDI: begin
            mux_a_sel  = 2'd2;
            rf_fun_sel = 2'b01;
            rf_r_sel   = rx_en;
          end
          OP_ALU: begin
            rf_outa_sel = rx_sel;
            rf_outb_sel = ry_sel;
            alu_fun_sel = imm[7:4];
            mux_c_sel   = 1'b0;
            mux_a_sel   = 2'd0;
            rf_fun_sel  = 2'b01;
            rf_r_sel    = rx_en;
          end
          OP_BRA: begin
            mux_b_sel   = 2'd2;
            arf_fun_sel = 2'b01;
            arf_reg_sel = 4'b1000;
          end
          OP_BEQ: begin
            if (z_latch) begin
              mux_b_sel   = 2'd2;
              arf_fun_sel = 2'b01;
              arf_reg_sel = 4'b1000;
            end
          end
          default: begin
          end
        endcase
      end
      E1: begin
        arf_outd_sel = 2'd0;
        mem_cs       = 1'b0;
        if (op == OP_ST) begin
          // Rx passes through the ALU unchanged onto the memory data bus
          mem_wr      = 1'b1;
          rf_outa_sel = rx_sel;
          mux_c_sel   = 1'b0;
          alu_fun_sel = 4'h0;
        end else begin
          mux_a_sel  = 2'd1;
          rf_fun_sel = 2'b01;
          rf_r_sel   = rx_en;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.RF_OutASel  = rf_outa_sel;
  assign bus.RF_OutBSel  = rf_outb_sel;
  assign bus.RF_FunSel   = rf_fun_sel;
  assign bus.RF_RSel     = rf_r_sel;
  assign bus.RF_TSel     = rf_t_sel;
  assign bus.ALU_FunSel  = alu_fun_sel;
  assign bus.ARF_OutCSel = 2'd0;
  assign bus.ARF_OutDSel = arf_outd_sel;
  assign bus.ARF_FunSel  = arf_fun_sel;
  assign bus.ARF_RegSel  = arf_reg_sel;
  assign bus.IR_LH       = ir_lh;
  assign bus.IR_Enable   = ir_enable;
  assign bus.IR_Funsel   = ir_funsel;
  assign bus.Mem_WR      = mem_wr;
  assign bus.Mem_CS      = mem_cs;
  assign bus.MuxASel     = mux_a_sel;
  assign bus.MuxBSel     = mux_b_sel;
  assign bus.MuxCSel     = mux_c_sel;
  assign bus.State       = state;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit with a small datapath and ISA model
module tb_control_unit;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  control_unit_if bus();

  control_unit dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // datapath environment
  logic [7:0]  image [256];
  logic [7:0]  mem   [256];
  logic        load_pending = 1'b0;
  logic [15:0] ir;
  logic [7:0]  rf_r [4];
  logic [7:0]  rf_t [4];
  logic [7:0]  pc, ar, sp, pc_past;
  logic [7:0]  out_a, out_b, alu_a, alu_out, mem_addr, mem_data, mux_a, mux_b;

  // ISA-level model results
  logic [2:0]  exp_q [$];
  logic [7:0]  m_mem [256];
  logic [7:0]  m_r [4];
  logic [7:0]  m_ar, m_pc;

  function automatic logic [7:0] alu_fn(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd1:    return b;
      4'd2:    return ~a;
      4'd3:    return ~b;
      4'd4:    return a + b;
      4'd5:    return a - b;
      4'd6:    return a & b;
      4'd7:    return a | b;
      4'd8:    return a ^ b;
      default: return a;
    endcase
  endfunction

  function automatic logic [7:0] reg_next(input logic [7:0] cur, input logic [1:0] fs, input logic [7:0] d);
    case (fs)
      2'b00:   return 8'h00;
      2'b01:   return d;
      2'b10:   return cur - 8'd1;
      default: return cur + 8'd1;
    endcase
  endfunction

  always_comb begin
    out_a   = bus.RF_OutASel[2] ? rf_r[bus.RF_OutASel[1:0]] : rf_t[bus.RF_OutASel[1:0]];
    out_b   = bus.RF_OutBSel[2] ? rf_r[bus.RF_OutBSel[1:0]] : rf_t[bus.RF_OutBSel[1:0]];
    alu_a   = bus.MuxCSel ? pc : out_a;
    alu_out = alu_fn(bus.ALU_FunSel, alu_a, out_b);
    case (bus.ARF_OutDSel)
      2'd0:    mem_addr = ar;
      2'd1:    mem_addr = sp;
      2'd2:    mem_addr = pc_past;
      default: mem_addr = pc;
    endcase
    mem_data = mem[mem_addr];
    case (bus.MuxASel)
      2'd0:    mux_a = alu_out;
      2'd1:    mux_a = mem_data;
      2'd2:    mux_a = ir[7:0];
      default: mux_a = pc;
    endcase
    case (bus.MuxBSel)
      2'd0:    mux_b = alu_out;
      2'd1:    mux_b = mem_data;
      2'd2:    mux_b = ir[7:0];
      default: mux_b = 8'h00;
    endcase
  end

  assign bus.IROut      = ir;
  assign bus.ALUOutFlag = {alu_out == 8'h00, 3'b000};

  always @(posedge Clock) begin
    if (load_pending) begin
      for (int i = 0; i < 256; i++) mem[i] <= image[i];
    end else if (!bus.Mem_CS && bus.Mem_WR) begin
      mem[mem_addr] <= alu_out;
    end
    if (bus.IR_Enable && bus.IR_Funsel == 2'b01) begin
      if (bus.IR_LH) ir[15:8] <= mem_data;
      else           ir[7:0]  <= mem_data;
    end
    for (int n = 0; n < 4; n++) begin
      if (bus.RF_RSel[3-n]) rf_r[n] <= reg_next(rf_r[n], bus.RF_FunSel, mux_a);
      if (bus.RF_TSel[3-n]) rf_t[n] <= reg_next(rf_t[n], bus.RF_FunSel, mux_a);
    end
    if (bus.ARF_RegSel[3]) pc      <= reg_next(pc, bus.ARF_FunSel, mux_b);
    if (bus.ARF_RegSel[2]) ar      <= reg_next(ar, bus.ARF_FunSel, mux_b);
    if (bus.ARF_RegSel[1]) sp      <= reg_next(sp, bus.ARF_FunSel, mux_b);
    if (bus.ARF_RegSel[0]) pc_past <= reg_next(pc_past, bus.ARF_FunSel, mux_b);
  end

  function automatic logic [15:0] mk(input logic [3:0] o, input logic [1:0] x, input logic [1:0] y, input logic [7:0] im);
    return {o, x, y, im};
  endfunction

  task automatic put_word(input logic [7:0] addr, input logic [15:0] w);
    image[addr]        = w[7:0];
    image[addr + 8'd1] = w[15:8];
  endtask

  task automatic clear_image();
    for (int i = 0; i < 256; i++) image[i] = 8'h00;
  endtask

  // instruction-level interpreter producing the expected state trace and final state
  task automatic model_run();
    logic [7:0]  r [4];
    logic [7:0]  mpc, mar, im;
    logic        z;
    logic [15:0] w;
    logic [3:0]  o;
    logic [1:0]  x, y;
    exp_q.delete();
    for (int i = 0; i < 256; i++) m_mem[i] = image[i];
    for (int i = 0; i < 4; i++) r[i] = 8'h00;
    mpc = 8'h00;
    mar = 8'h00;
    z   = 1'b0;
    exp_q.push_back(3'd0);
    for (int n = 0; n < 200; n++) begin
      w = {m_mem[mpc + 8'd1], m_mem[mpc]};
      mpc = mpc + 8'd2;
      exp_q.push_back(3'd1);
      exp_q.push_back(3'd2);
      exp_q.push_back(3'd3);
      o = w[15:12]; x = w[11:10]; y = w[9:8]; im = w[7:0];
      if (o == 4'hF) begin
        repeat (10) exp_q.push_back(3'd5);
        break;
      end
      case (o)
        4'h0: begin mar = im; r[x] = m_mem[mar]; exp_q.push_back(3'd4); end
        4'h1: begin mar = im; m_mem[mar] = r[x]; exp_q.push_back(3'd4); end
        4'h2: r[x] = im;
        4'h3: begin r[x] = alu_fn(im[7:4], r[x], r[y]); z = (r[x] == 8'h00); end
        4'h4: mpc = im;
        4'h5: if (z) mpc = im;
        default: ;
      endcase
    end
    for (int i = 0; i < 4; i++) m_r[i] = r[i];
    m_ar = mar;
    m_pc = mpc;
  endtask

  // load image under reset, check the INIT decode, release reset on a falling edge
  task automatic start_program();
    @(negedge Clock);
    Reset = 1'b1;
    bus.Step = 1'b1;
    load_pending = 1'b1;
    @(posedge Clock);
    #1 load_pending = 1'b0;
    @(negedge Clock);
    checks++;
    if ({bus.State, bus.RF_RSel, bus.RF_TSel, bus.ARF_RegSel, bus.RF_FunSel, bus.ARF_FunSel,
         bus.Mem_CS, bus.Mem_WR, bus.IR_Enable} !==
        {3'd0, 4'hF, 4'hF, 4'hF, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0})
      begin errors++; $display("FAIL init_decode: state=%0d rsel=%h tsel=%h arsel=%h cs=%b wr=%b",
        bus.State, bus.RF_RSel, bus.RF_TSel, bus.ARF_RegSel, bus.Mem_CS, bus.Mem_WR); end
    Reset = 1'b0;
  endtask

  task automatic run_program(input string name);
    model_run();
    start_program();
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) begin
`ifndef SINGLE_STEP_EN
        bus.Step = 1'($urandom_range(0, 1));
`endif
        @(negedge Clock);
      end
      checks++;
      if (bus.State !== exp_q[k]) begin
        errors++;
        $display("FAIL %s state[%0d]: got %0d expected %0d", name, k, bus.State, exp_q[k]);
        break;
      end
      if (bus.State == 3'd1 || bus.State == 3'd2) begin
        checks++;
        if ({bus.ARF_OutDSel, bus.Mem_CS, bus.Mem_WR, bus.IR_Enable, bus.IR_Funsel, bus.IR_LH,
             bus.ARF_RegSel, bus.ARF_FunSel, bus.RF_RSel} !==
            {2'd3, 1'b0, 1'b0, 1'b1, 2'b01, bus.State == 3'd2, 4'b1000, 2'b11, 4'h0})
          begin errors++; $display("FAIL %s fetch_decode: state=%0d dsel=%0d cs=%b ire=%b lh=%b arsel=%h arfun=%0d",
            name, bus.State, bus.ARF_OutDSel, bus.Mem_CS, bus.IR_Enable, bus.IR_LH, bus.ARF_RegSel, bus.ARF_FunSel); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rf_r[i] !== m_r[i]) begin errors++;
        $display("FAIL %s R%0d: got %h expected %h", name, i + 1, rf_r[i], m_r[i]); end
    end
    checks++;
    if ({ar, pc} !== {m_ar, m_pc}) begin errors++;
      $display("FAIL %s ar_pc: got AR=%h PC=%h expected AR=%h PC=%h", name, ar, pc, m_ar, m_pc); end
    begin
      int bad = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== m_mem[a]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL %s memory: %0d bytes differ, expected 0", name, bad); end
    end
  endtask

  task automatic test_reset();
    clear_image();
    put_word(8'h00, 16'hF000);
    start_program();
    checks++;
    if (bus.ARF_OutCSel !== 2'd0) begin errors++; $display("FAIL reset_outc: got %0d expected 0", bus.ARF_OutCSel); end
    @(negedge Clock);
    checks++;
    if (bus.State !== 3'd1) begin errors++; $display("FAIL reset_one_init: got %0d expected 1", bus.State); end
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
  endtask

  task automatic test_ldi();
    clear_image();
    image[0] = 8'h42; image[1] = 8'h20;
    put_word(8'h02, 16'hF000);
    run_program("ldi");
    checks++;
    if (rf_r[0] !== 8'h42) begin errors++; $display("FAIL ldi_r1: got %h expected 42", rf_r[0]); end
  endtask

  task automatic test_ld();
    clear_image();
    put_word(8'h00, 16'h2042);
    image[2] = 8'h10; image[3] = 8'h04;
    put_word(8'h04, 16'hF000);
    image[8'h10] = 8'h5A;
    run_program("ld");
    checks++;
    if ({ar, rf_r[1]} !== {8'h10, 8'h5A}) begin errors++;
      $display("FAIL ld_result: got AR=%h R2=%h expected AR=10 R2=5A", ar, rf_r[1]); end
  endtask

  task automatic test_alu_beq();
    clear_image();
    put_word(8'h00, 16'h2042);
    put_word(8'h02, 16'h3050);
    put_word(8'h04, 16'h5008);
    put_word(8'h06, 16'h24EE);
    put_word(8'h08, 16'hF000);
    run_program("alu_beq");
    checks++;
    if ({rf_r[0], rf_r[1]} !== {8'h00, 8'h00}) begin errors++;
      $display("FAIL alu_beq_regs: got R1=%h R2=%h expected 00 00", rf_r[0], rf_r[1]); end
  endtask

  task automatic test_z_cleared_by_reset();
    clear_image();
    put_word(8'h00, 16'h3050);
    put_word(8'h02, 16'hF000);
    run_program("z_set");
    clear_image();
    put_word(8'h00, 16'h5008);
    put_word(8'h02, 16'h2411);
    put_word(8'h04, 16'hF000);
    put_word(8'h08, 16'hF000);
    run_program("z_reset");
  endtask

  task automatic test_halt();
    clear_image();
    put_word(8'h00, 16'hF000);
    run_program("halt");
    for (int c = 0; c < 12; c++) begin
      @(negedge Clock);
      checks++;
      if ({bus.State, bus.Mem_CS, bus.Mem_WR, bus.IR_Enable, bus.RF_RSel, bus.RF_TSel, bus.ARF_RegSel,
           bus.RF_FunSel, bus.ARF_FunSel, bus.MuxASel, bus.MuxBSel, bus.ALU_FunSel} !==
          {3'd5, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 2'd0, 2'd0, 2'd0, 4'h0})
        begin errors++; $display("FAIL halt_idle[%0d]: state=%0d cs=%b rsel=%h arsel=%h",
          c, bus.State, bus.Mem_CS, bus.RF_RSel, bus.ARF_RegSel); end
    end
  endtask

  task automatic test_reset_during_store();
    int guard;
    clear_image();
    put_word(8'h00, 16'h2077);
    put_word(8'h02, 16'h1090);
    put_word(8'h04, 16'hF000);
    image[8'h90] = 8'h33;
    start_program();
    guard = 0;
    while (bus.State !== 3'd4 && guard < 20) begin
      @(negedge Clock);
      guard++;
    end
    checks++;
    if (bus.State !== 3'd4) begin errors++; $display("FAIL st_reach_e1: got %0d expected 4", bus.State); end
    checks++;
    if ({bus.Mem_CS, bus.Mem_WR, bus.RF_OutASel} !== {1'b0, 1'b1, 3'd4}) begin errors++;
      $display("FAIL st_e1_decode: cs=%b wr=%b outa=%0d expected 0 1 4", bus.Mem_CS, bus.Mem_WR, bus.RF_OutASel); end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({bus.Mem_WR, bus.Mem_CS, bus.State} !== {1'b0, 1'b1, 3'd0}) begin errors++;
      $display("FAIL st_abort: wr=%b cs=%b state=%0d expected 0 1 0", bus.Mem_WR, bus.Mem_CS, bus.State); end
    @(negedge Clock);
    checks++;
    if (mem[8'h90] !== 8'h33) begin errors++; $display("FAIL st_mem_kept: got %h expected 33", mem[8'h90]); end
    Reset = 1'b0;
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    clear_image();
    put_word(8'h00, 16'h2042);
    put_word(8'h02, 16'hF000);
    start_program();
    bus.Step = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      checks++;
      if ({bus.State, pc, bus.Mem_CS, bus.IR_Enable} !== {3'd1, 8'h00, 1'b1, 1'b0}) begin errors++;
        $display("FAIL step_hold[%0d]: state=%0d pc=%h cs=%b", c, bus.State, pc, bus.Mem_CS); end
    end
    bus.Step = 1'b1;
    @(negedge Clock);
    checks++;
    if ({bus.State, pc} !== {3'd2, 8'h01}) begin errors++;
      $display("FAIL step_go: state=%0d pc=%h expected 2 01", bus.State, pc); end
  endtask
`endif

  task automatic test_random();
    for (int p = 0; p < 20; p++) begin
      int n;
      n = $urandom_range(4, 28);
      for (int i = 0; i < 256; i++) image[i] = 8'($urandom);
      for (int i = 0; i < n; i++) begin
        logic [1:0] x, y;
        logic [15:0] w;
        x = 2'($urandom); y = 2'($urandom);
        case ($urandom_range(0, 7))
          0: w = mk(4'h0, x, y, 8'h80 | 8'($urandom_range(0, 127)));
          1: w = mk(4'h1, x, y, 8'h80 | 8'($urandom_range(0, 127)));
          2: w = mk(4'h2, x, y, 8'($urandom));
          4: w = (i + 2 <= n) ? mk(4'h4, x, y, 8'(2 * (i + 2))) : mk(4'h6, x, y, 8'h00);
          5: w = (i + 2 <= n) ? mk(4'h5, x, y, 8'(2 * (i + 2))) : mk(4'h7, x, y, 8'h00);
          6: w = mk(4'($urandom_range(6, 14)), x, y, 8'($urandom));
          default: w = mk(4'h3, x, y, 8'($urandom));
        endcase
        put_word(8'(2 * i), w);
      end
      put_word(8'(2 * n), 16'hF000);
      run_program($sformatf("rand%0d", p));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Step = 1'b1;
    test_reset();
    test_ldi();
    test_ld();
    test_alu_beq();
    test_z_cleared_by_reset();
    test_halt();
    test_reset_during_store();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
